// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the common data bus between
// the execution-unit wrappers and registers the winning unit's result.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   unit_valid / unit_ready   per-unit ready/valid handshake (ready one-hot or zero)
//   unit_rs_id, unit_reg_addr,
//   unit_result, unit_cr0_xer per-unit result payload
//   cdb_valid / cdb_ready     registered CDB output handshake
//   cdb_rs_id, cdb_reg_addr,
//   cdb_result, cdb_cr0_xer   registered CDB payload

package cdb_arbiter_pkg;
    // CR0 field (lt, gt, eq, so) plus the XER bits a result can update
    typedef struct packed {
        logic [3:0] cr0;
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_UNITS-1:0]                    unit_valid,
    output logic [NUM_UNITS-1:0]                    unit_ready,
    input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]   unit_rs_id,
    input  logic [NUM_UNITS-1:0][4:0]               unit_reg_addr,
    input  logic [NUM_UNITS-1:0][31:0]              unit_result,
    input  cond_exception_t [NUM_UNITS-1:0]         unit_cr0_xer,
    output logic                                    cdb_valid,
    input  logic                                    cdb_ready,
    output logic [RS_ID_WIDTH-1:0]                  cdb_rs_id,
    output logic [4:0]                              cdb_reg_addr,
    output logic [31:0]                             cdb_result,
    output cond_exception_t                         cdb_cr0_xer
);

    // A single unit still gets a 1-bit pointer that stays at zero
    localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             grant_found;
    logic             can_load;
    logic             transfer;

    // Output stage can accept a new result when empty or draining this cycle
    assign can_load = !cdb_valid || cdb_ready;
    assign transfer = rst && can_load && grant_found;

    // Round-robin scan starting at rr_ptr; first valid unit wins
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_UNITS;
            if (!grant_found && unit_valid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NUM_UNITS-1
    assign ptr_next = (32'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + PTR_W'(1);

    // Ready is held low while reset is asserted, independent of register state
    always_comb begin
        unit_ready = '0;
        if (transfer) begin
            unit_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            cdb_valid    <= 1'b0;
            cdb_rs_id    <= '0;
            cdb_reg_addr <= '0;
            cdb_result   <= '0;
            cdb_cr0_xer  <= '0;
        end else if (transfer) begin
            rr_ptr       <= ptr_next;
            cdb_valid    <= 1'b1;
            cdb_rs_id    <= unit_rs_id[grant_idx];
            cdb_reg_addr <= unit_reg_addr[grant_idx];
            cdb_result   <= unit_result[grant_idx];
            cdb_cr0_xer  <= unit_cr0_xer[grant_idx];
        end else if (cdb_ready) begin
            cdb_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: 4-unit instance driven by directed
// steps with a reference model and payload scoreboard, plus a 1-unit instance.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic [RW-1:0]   rs;
        logic [4:0]      ra;
        logic [31:0]     res;
        cond_exception_t cx;
    } pl_t;

    logic clk;
    logic rst;

    // 4-unit instance
    logic [N-1:0]                u_valid;
    logic [N-1:0]                u_ready;
    logic [N-1:0][RW-1:0]        u_rs;
    logic [N-1:0][4:0]           u_ra;
    logic [N-1:0][31:0]          u_res;
    cond_exception_t [N-1:0]     u_cx;
    logic                        cdb_valid;
    logic                        cdb_ready;
    logic [RW-1:0]               cdb_rs;
    logic [4:0]                  cdb_ra;
    logic [31:0]                 cdb_res;
    cond_exception_t             cdb_cx;

    // 1-unit instance
    logic [0:0]                  s_valid;
    logic [0:0]                  s_ready;
    logic [0:0][RW-1:0]          s_rs;
    logic [0:0][4:0]             s_ra;
    logic [0:0][31:0]            s_res;
    cond_exception_t [0:0]       s_cx;
    logic                        s_cdb_valid;
    logic                        s_cdb_ready;
    logic [RW-1:0]               s_cdb_rs;
    logic [4:0]                  s_cdb_ra;
    logic [31:0]                 s_cdb_res;
    cond_exception_t             s_cdb_cx;

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .unit_valid(u_valid), .unit_ready(u_ready),
        .unit_rs_id(u_rs), .unit_reg_addr(u_ra),
        .unit_result(u_res), .unit_cr0_xer(u_cx),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_rs_id(cdb_rs), .cdb_reg_addr(cdb_ra),
        .cdb_result(cdb_res), .cdb_cr0_xer(cdb_cx)
    );

    cdb_arbiter #(.NUM_UNITS(1), .RS_ID_WIDTH(RW)) dut1 (
        .clk(clk), .rst(rst),
        .unit_valid(s_valid), .unit_ready(s_ready),
        .unit_rs_id(s_rs), .unit_reg_addr(s_ra),
        .unit_result(s_res), .unit_cr0_xer(s_cx),
        .cdb_valid(s_cdb_valid), .cdb_ready(s_cdb_ready),
        .cdb_rs_id(s_cdb_rs), .cdb_reg_addr(s_cdb_ra),
        .cdb_result(s_cdb_res), .cdb_cr0_xer(s_cdb_cx)
    );

    always #5 clk = ~clk;

    int   n_total;
    int   n_pass;
    int   m_ptr;
    logic m_cv;
    pl_t  exp_q[$];

    function automatic pl_t unit_pl(int i);
        return {u_rs[i], u_ra[i], u_res[i], u_cx[i]};
    endfunction

    function automatic pl_t cdb_pl();
        return {cdb_rs, cdb_ra, cdb_res, cdb_cx};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic new_result(int i);
        u_rs[i]  = RW'($urandom);
        u_ra[i]  = 5'($urandom);
        u_res[i] = $urandom;
        u_cx[i]  = cond_exception_t'(7'($urandom));
    endtask

    // One clock: entered just after a falling edge with inputs already driven
    task automatic cycle(string tag);
        int         g;
        int         idx;
        logic       found;
        logic       can;
        logic       xfer;
        logic       drain;
        logic [N-1:0] exp_rdy;
        #1;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && u_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        can     = !m_cv || cdb_ready;
        xfer    = found && can;
        exp_rdy = xfer ? (N'(1) << g) : '0;
        chk({tag, " ready"}, 64'(u_ready), 64'(exp_rdy));
        drain = m_cv && cdb_ready;
        @(posedge clk);
        if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
        if (xfer) begin
            exp_q.push_back(unit_pl(g));
            m_ptr = (g + 1) % N;
        end
        m_cv = xfer ? 1'b1 : (drain ? 1'b0 : m_cv);
        @(negedge clk);
        chk({tag, " cdb_valid"}, 64'(cdb_valid), 64'(m_cv));
        if (m_cv && exp_q.size() > 0)
            chk({tag, " payload"}, 64'(cdb_pl()), 64'(exp_q[0]));
        if (xfer) new_result(g);
    endtask

    initial begin
        logic [31:0] v;
        clk = 1'b0; rst = 1'b0;
        n_total = 0; n_pass = 0; m_ptr = 0; m_cv = 1'b0;
        u_valid = '0; cdb_ready = 1'b0;
        for (int i = 0; i < N; i++) new_result(i);
        s_valid = '0; s_rs = '0; s_ra = '0; s_res = '0; s_cx = '0; s_cdb_ready = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst ready", 64'(u_ready), 64'd0);
        chk("rst payload", 64'(cdb_pl()), 64'd0);
        rst = 1'b1;

        // Single request from unit 2
        u_rs[2] = RW'(7); u_res[2] = 32'hDEADBEEF;
        u_valid = 4'b0100; cdb_ready = 1'b1;
        cycle("t1");
        chk("t1 rs_id", 64'(cdb_rs), 64'd7);
        chk("t1 result", 64'(cdb_res), 64'hDEADBEEF);

        // Pointer now at 3: unit 3 beats unit 0
        u_valid = 4'b1001;
        cycle("ptr3");
        u_valid = 4'b0000;
        cycle("idle");

        // Load unit 1, then stall the CDB with units 0 and 3 waiting
        u_valid = 4'b0010;
        cycle("s_load");
        u_valid = 4'b1001; cdb_ready = 1'b0;
        repeat (3) cycle("stall");
        cdb_ready = 1'b1;
        cycle("unstall");

        // Wrap: pointer at 0, units 1 and 2 requesting
        u_valid = 4'b0110;
        cycle("wrap1");
        u_valid = 4'b0100;
        cycle("wrap2");

        // Mid-stream asynchronous reset
        u_valid = 4'b1111;
        cycle("pre_rst");
        cdb_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async cdb_valid", 64'(cdb_valid), 64'd0);
        chk("async ready", 64'(u_ready), 64'd0);
        m_ptr = 0; m_cv = 1'b0; exp_q.delete();
        @(negedge clk);
        rst = 1'b1; cdb_ready = 1'b1;

        // Sustained round-robin after reset, unit 0 first
        #1 chk("rr first", 64'(u_ready), 64'd1);
        repeat (8) cycle("rr");

        // Random traffic with backpressure
        for (int i = 0; i < 24; i++) begin
            u_valid   = N'($urandom);
            cdb_ready = 1'(($urandom % 4) != 0);
            cycle("rand");
        end
        u_valid = '0; cdb_ready = 1'b1;
        cycle("drain");

        // Single-unit instance: ready follows can_load, no bubbles
        s_valid = 1'b1; s_cdb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = $urandom; s_res[0] = v;
            #1 chk("n1 ready", 64'(s_ready), 64'd1);
            @(posedge clk); @(negedge clk);
            chk("n1 valid", 64'(s_cdb_valid), 64'd1);
            chk("n1 result", 64'(s_cdb_res), 64'(v));
        end
        s_res[0] = ~v; s_cdb_ready = 1'b0;
        #1 chk("n1 stall ready", 64'(s_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("n1 stall valid", 64'(s_cdb_valid), 64'd1);
        chk("n1 stall result", 64'(s_cdb_res), 64'(v));
        s_valid = 1'b0; s_cdb_ready = 1'b1;
        #1 chk("n1 idle ready", 64'(s_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("n1 drained", 64'(s_cdb_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
